// File: rtl/code_tick_gen_if.sv
// code_tick_gen_if: load/enable controls and strobe/readback outputs of the NCO chip tick source
interface code_tick_gen_if #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 10
);
  logic             wr;
  logic [ACC_W-1:0] fcw_in;
  logic [CNT_W-1:0] chip_init;
  logic             enable;
  logic             plusSignal;
  logic             overSignal;
  logic [CNT_W-1:0] chip_idx;
  logic [ACC_W-1:0] fcw;
  modport master (
    output wr, fcw_in, chip_init, enable,
    input  plusSignal, overSignal, chip_idx, fcw
  );
  modport slave (
    input  wr, fcw_in, chip_init, enable,
    output plusSignal, overSignal, chip_idx, fcw
  );
endinterface

// File: rtl/code_tick_gen.sv
// code_tick_gen: phase-accumulator chip tick and code-period-end strobe generator
module code_tick_gen #(
  parameter int ACC_W    = 32,
  parameter int CHIP_LEN = 1023,
  parameter int CNT_W    = 10
) (
  input logic              clk,
  input logic              reset,
  code_tick_gen_if.slave   bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHIP_LEN - 1);
  logic [ACC_W-1:0] acc_q, acc_d, fcw_q, fcw_d, sum;
  logic [CNT_W-1:0] idx_q, idx_d, init_c;
  logic             plus_q, plus_d, over_q, over_d, carry, last;
  assign {carry, sum} = {1'b0, acc_q} + {1'b0, fcw_q};
  assign last   = idx_q == LAST;
  // out-of-range preloads clamp to chip 0 rather than flagging an error
  assign init_c = (32'(bus.chip_init) >= CHIP_LEN) ? '0 : bus.chip_init;
  always_comb begin
    acc_d  = acc_q;
    fcw_d  = fcw_q;
    idx_d  = idx_q;
    plus_d = 1'b0;
    over_d = 1'b0;
    if (bus.wr) begin
      fcw_d = bus.fcw_in;
      acc_d = '0;
      idx_d = init_c;
    end else if (bus.enable) begin
      acc_d  = sum;
      plus_d = carry;
      over_d = carry & last;
      idx_d  = carry ? (last ? '0 : idx_q + CNT_W'(1)) : idx_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      fcw_q  <= '0;
      idx_q  <= '0;
      plus_q <= 1'b0;
      over_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fcw_q  <= fcw_d;
      idx_q  <= idx_d;
      plus_q <= plus_d;
      over_q <= over_d;
    end
  end
  assign bus.plusSignal = plus_q;
  assign bus.overSignal = over_q;
  assign bus.chip_idx   = idx_q;
  assign bus.fcw        = fcw_q;
endmodule

// File: tb/tb_code_tick_gen.sv
// tb_code_tick_gen: vector table, directed sequences and random traffic against a phase model
module tb_code_tick_gen;
  logic        clk = 0, rst = 0, wr = 0, en = 0;
  logic [31:0] fi = 0;
  logic [9:0]  ci = 0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  code_tick_gen_if #(.ACC_W(32), .CNT_W(10)) ifa ();
  code_tick_gen_if #(.ACC_W(32), .CNT_W(3))  ifb ();
  assign ifa.wr = wr;
  assign ifa.fcw_in = fi;
  assign ifa.chip_init = ci;
  assign ifa.enable = en;
  assign ifb.wr = wr;
  assign ifb.fcw_in = fi;
  assign ifb.chip_init = ci[2:0];
  assign ifb.enable = en;
  code_tick_gen #(.ACC_W(32), .CHIP_LEN(1023), .CNT_W(10)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
  code_tick_gen #(.ACC_W(32), .CHIP_LEN(4),    .CNT_W(3))  dut_b (.clk(clk), .reset(rst), .bus(ifb));
  longint unsigned m_acc[2];
  longint unsigned m_fcw[2];
  int m_idx[2];
  bit m_plus[2], m_over[2];
  int len[2] = '{1023, 4};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_step(input int k, input bit r, input bit w, input longint unsigned f, input int c, input bit e);
    longint unsigned s;
    if (r) begin
      m_acc[k] = 0; m_fcw[k] = 0; m_idx[k] = 0; m_plus[k] = 0; m_over[k] = 0;
    end else if (w) begin
      m_fcw[k] = f; m_acc[k] = 0; m_plus[k] = 0; m_over[k] = 0;
      m_idx[k] = (c >= len[k]) ? 0 : c;
    end else if (e) begin
      s = m_acc[k] + m_fcw[k];
      m_plus[k] = s >= 64'h1_0000_0000;
      m_over[k] = m_plus[k] && m_idx[k] == len[k] - 1;
      m_acc[k] = s % 64'h1_0000_0000;
      if (m_plus[k]) m_idx[k] = (m_idx[k] + 1) % len[k];
    end else begin
      m_plus[k] = 0; m_over[k] = 0;
    end
  endtask
  task automatic step(input bit r, input bit w, input logic [31:0] f, input logic [9:0] c, input bit e);
    @(negedge clk);
    rst = r; wr = w; fi = f; ci = c; en = e;
    @(posedge clk);
    model_step(0, r, w, f, int'(c), e);
    model_step(1, r, w, f, int'(c) % 8, e);
    #1;
    chk("a_plus", 32'(ifa.plusSignal), 32'(m_plus[0]));
    chk("a_over", 32'(ifa.overSignal), 32'(m_over[0]));
    chk("a_idx",  32'(ifa.chip_idx),   32'(m_idx[0]));
    chk("a_fcw",  ifa.fcw,             32'(m_fcw[0]));
    chk("b_plus", 32'(ifb.plusSignal), 32'(m_plus[1]));
    chk("b_over", 32'(ifb.overSignal), 32'(m_over[1]));
    chk("b_idx",  32'(ifb.chip_idx),   32'(m_idx[1]));
    chk("b_fcw",  ifb.fcw,             32'(m_fcw[1]));
  endtask
  typedef struct {
    bit r, w, e;
    logic [31:0] f;
    logic [9:0] c;
    bit p, oa;
    int ia;
    bit ob;
    int ib;
    logic [31:0] fx;
  } vec_t;
  vec_t tbl[13];
  int exp_b_idx[6] = '{0, 1, 2, 3, 0, 1};
  int exp_b_over[6] = '{0, 0, 0, 0, 1, 0};
  initial begin
    tbl[0]  = '{1, 0, 0, 32'h0,         10'd0,    0, 0, 0,    0, 0, 32'h0};
    tbl[1]  = '{0, 1, 0, 32'h8000_0000, 10'd1022, 0, 0, 1022, 0, 0, 32'h8000_0000};
    tbl[2]  = '{0, 0, 1, 32'h0,         10'd0,    0, 0, 1022, 0, 0, 32'h8000_0000};
    tbl[3]  = '{0, 0, 1, 32'h0,         10'd0,    1, 1, 0,    0, 1, 32'h8000_0000};
    tbl[4]  = '{0, 0, 0, 32'h0,         10'd0,    0, 0, 0,    0, 1, 32'h8000_0000};
    tbl[5]  = '{0, 0, 1, 32'h0,         10'd0,    0, 0, 0,    0, 1, 32'h8000_0000};
    tbl[6]  = '{1, 1, 1, 32'h1234,      10'd5,    0, 0, 0,    0, 0, 32'h0};
    tbl[7]  = '{0, 1, 1, 32'hFFFF_FFFF, 10'd3,    0, 0, 3,    0, 3, 32'hFFFF_FFFF};
    tbl[8]  = '{0, 0, 1, 32'h0,         10'd0,    0, 0, 3,    0, 3, 32'hFFFF_FFFF};
    tbl[9]  = '{0, 0, 1, 32'h0,         10'd0,    1, 0, 4,    1, 0, 32'hFFFF_FFFF};
    tbl[10] = '{0, 0, 1, 32'h0,         10'd0,    1, 0, 5,    0, 1, 32'hFFFF_FFFF};
    tbl[11] = '{0, 1, 1, 32'h0,         10'd1023, 0, 0, 0,    0, 0, 32'h0};
    tbl[12] = '{0, 0, 1, 32'h0,         10'd0,    0, 0, 0,    0, 0, 32'h0};
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].f, tbl[i].c, tbl[i].e);
      chk($sformatf("v%0d_plus", i),   32'(ifa.plusSignal), 32'(tbl[i].p));
      chk($sformatf("v%0d_over_a", i), 32'(ifa.overSignal), 32'(tbl[i].oa));
      chk($sformatf("v%0d_idx_a", i),  32'(ifa.chip_idx),   32'(tbl[i].ia));
      chk($sformatf("v%0d_over_b", i), 32'(ifb.overSignal), 32'(tbl[i].ob));
      chk($sformatf("v%0d_idx_b", i),  32'(ifb.chip_idx),   32'(tbl[i].ib));
      chk($sformatf("v%0d_fcw", i),    ifa.fcw,             tbl[i].fx);
    end
    step(0, 1, 32'h8000_0000, 10'd0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 1);
      chk("half_plus", 32'(ifa.plusSignal), 32'(i % 2 == 1));
      chk("half_idx",  32'(ifa.chip_idx),   32'((i + 1) / 2));
    end
    step(0, 1, 32'hFFFF_FFFF, 10'd0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 1);
      chk("max_plus", 32'(ifb.plusSignal), 32'(i > 0));
      chk("max_idx",  32'(ifb.chip_idx),   32'(exp_b_idx[i]));
      chk("max_over", 32'(ifb.overSignal), 32'(exp_b_over[i]));
    end
    step(0, 1, 32'h8000_0000, 10'd0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, i % 2 == 0);
      if (i % 2 == 1) chk("frozen_plus", 32'(ifa.plusSignal), 32'h0);
    end
    step(0, 1, 32'h8000_0000, 10'd0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 1, 32'h4000_0000, 10'd7, 1);
    chk("rst_wins_fcw", ifa.fcw, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] f;
      logic [9:0]  c;
      case ($urandom_range(3))
        0: f = $urandom;
        1: f = 32'h8000_0000;
        2: f = 32'hF000_0000 | $urandom;
        default: f = $urandom >> 4;
      endcase
      c = $urandom_range(1) ? 10'($urandom_range(1023)) : 10'($urandom_range(1023, 1015));
      step($urandom_range(99) < 2, $urandom_range(99) < 5, f, c, $urandom_range(99) < 75);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
